// File: rtl/mem_ss_rst_cal_seq.sv
// mem_ss_rst_cal_seq: mem_ss reset handshake and EMIF calibration bring-up sequencer
module mem_ss_rst_cal_seq #(
    parameter int NUM_CH       = 4,
    parameter int RST_HOLD_CYC = 16,
    parameter int ACK_TIMEOUT  = 4096,
    parameter int CAL_TIMEOUT  = 1048576,
    parameter int STABLE_CYC   = 3,
    parameter int MAX_RETRY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              mem_ss_rst_req,
    input  logic              mem_ss_rst_ack_n,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic              busy,
    output logic              ready,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [1:0]        retry_cnt,
    output logic [NUM_CH-1:0] cal_status,
    output logic [2:0]        state_o
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ASSERT_RST = 3'd1;
    localparam logic [2:0] WAIT_ACK   = 3'd2;
    localparam logic [2:0] RELEASE    = 3'd3;
    localparam logic [2:0] WAIT_CAL   = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;
    localparam logic [2:0] ERROR      = 3'd6;
    localparam int HW = $clog2(RST_HOLD_CYC) + 1;
    localparam int TW = $clog2(CAL_TIMEOUT > ACK_TIMEOUT ? CAL_TIMEOUT : ACK_TIMEOUT) + 1;
    localparam int SW = $clog2(STABLE_CYC) + 1;
    logic [2:0]        state, nxt;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     to_cnt;
    logic [SW-1:0]     stable_cnt;
    logic [NUM_CH-1:0] mask_q;
    logic              fail, cal_ok, cal_bad, restart, stay;
    logic [1:0]        fail_code;
    // Failure priority in WAIT_CAL: cal_fail, then completed success, then timeout.
    always_comb begin
        cal_ok    = (cal_success & mask_q) == mask_q;
        cal_bad   = |(cal_fail & mask_q);
        restart   = start && (state == IDLE || state == DONE || state == ERROR);
        nxt       = state;
        fail      = 1'b0;
        fail_code = 2'd0;
        case (state)
            IDLE, DONE, ERROR: nxt = start ? ASSERT_RST : state;
            ASSERT_RST: nxt = (hold_cnt == HW'(RST_HOLD_CYC - 1)) ? WAIT_ACK : state;
            WAIT_ACK: begin
                nxt       = !mem_ss_rst_ack_n ? RELEASE : state;
                fail      = mem_ss_rst_ack_n && to_cnt == TW'(ACK_TIMEOUT - 1);
                fail_code = 2'd1;
            end
            RELEASE: begin
                nxt       = mem_ss_rst_ack_n ? WAIT_CAL : state;
                fail      = !mem_ss_rst_ack_n && to_cnt == TW'(ACK_TIMEOUT - 1);
                fail_code = 2'd1;
            end
            WAIT_CAL: begin
                nxt       = (cal_ok && stable_cnt == SW'(STABLE_CYC - 1)) ? DONE : state;
                fail      = cal_bad || (nxt != DONE && to_cnt == TW'(CAL_TIMEOUT - 1));
                fail_code = cal_bad ? 2'd3 : 2'd2;
            end
            default: nxt = IDLE;
        endcase
        if (fail)
            nxt = (retry_cnt < 2'(MAX_RETRY)) ? ASSERT_RST : ERROR;
        stay = nxt == state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            stable_cnt     <= '0;
            mask_q         <= '0;
            retry_cnt      <= 2'd0;
            err_code       <= 2'd0;
            cal_status     <= '0;
            mem_ss_rst_req <= 1'b0;
            busy           <= 1'b0;
            ready          <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= nxt;
            hold_cnt       <= (stay && state == ASSERT_RST) ? hold_cnt + 1'b1 : '0;
            to_cnt         <= (stay && (state == WAIT_ACK || state == RELEASE || state == WAIT_CAL)) ? to_cnt + 1'b1 : '0;
            stable_cnt     <= (stay && state == WAIT_CAL && cal_ok) ? stable_cnt + 1'b1 : '0;
            mask_q         <= restart ? ch_mask : mask_q;
            retry_cnt      <= restart ? 2'd0 : (fail && nxt == ASSERT_RST) ? retry_cnt + 2'd1 : retry_cnt;
            err_code       <= restart ? 2'd0 : fail ? fail_code : err_code;
            cal_status     <= cal_success & mask_q;
            mem_ss_rst_req <= nxt == ASSERT_RST || nxt == WAIT_ACK;
            busy           <= nxt != IDLE && nxt != DONE && nxt != ERROR;
            ready          <= nxt == DONE;
            error          <= nxt == ERROR;
        end
    end
    assign state_o = state;
endmodule

// File: tb/tb_mem_ss_rst_cal_seq.sv
// tb_mem_ss_rst_cal_seq: directed bring-up, timeout, retry and reset scenarios for mem_ss_rst_cal_seq
module tb_mem_ss_rst_cal_seq;
    logic       clk = 1'b0;
    logic       rst, start, mem_ss_rst_req, mem_ss_rst_ack_n, busy, ready, error;
    logic [3:0] ch_mask, cal_success, cal_fail, cal_status;
    logic [1:0] err_code, retry_cnt;
    logic [2:0] state_o;
    int         n_chk = 0;
    int         n_fail = 0;

    mem_ss_rst_cal_seq #(.CAL_TIMEOUT(512)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .mem_ss_rst_req(mem_ss_rst_req), .mem_ss_rst_ack_n(mem_ss_rst_ack_n),
        .cal_success(cal_success), .cal_fail(cal_fail), .busy(busy), .ready(ready),
        .error(error), .err_code(err_code), .retry_cnt(retry_cnt),
        .cal_status(cal_status), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int n = 0;
        while (state_o !== s && n < bound) begin
            step(1);
            n++;
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    task automatic pulse_start(input logic [3:0] m);
        ch_mask = m;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Drive a prompt ack handshake; returns on the first cycle of WAIT_CAL.
    task automatic pass_ack();
        wait_state(3'd2, 40, "reach_wait_ack");
        mem_ss_rst_ack_n = 1'b0;
        wait_state(3'd3, 10, "reach_release");
        mem_ss_rst_ack_n = 1'b1;
        wait_state(3'd4, 10, "reach_wait_cal");
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'd0);
        chk({tag, "_rst_req"}, 32'(mem_ss_rst_req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        chk({tag, "_cal_status"}, 32'(cal_status), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ch_mask = 4'h0; mem_ss_rst_ack_n = 1'b1;
        cal_success = 4'hF; cal_fail = 4'h0;
        step(3);
        chk_idle_outputs("reset");
        rst = 1'b0;
        cal_success = 4'h0;
        step(2);
        chk("idle_no_start", 32'(state_o), 32'd0);

        // Nominal: 16 hold cycles + 5 ack cycles of rst_req, ready 3 cycles after success
        pulse_start(4'b0011);
        chk("nom_assert_state", 32'(state_o), 32'd1);
        chk("nom_assert_req", 32'(mem_ss_rst_req), 32'd1);
        chk("nom_assert_busy", 32'(busy), 32'd1);
        step(15);
        chk("nom_hold_last", 32'(state_o), 32'd1);
        step(1);
        chk("nom_wait_ack", 32'(state_o), 32'd2);
        chk("nom_wait_ack_req", 32'(mem_ss_rst_req), 32'd1);
        step(4);
        chk("nom_ack_pending", 32'(state_o), 32'd2);
        mem_ss_rst_ack_n = 1'b0;
        step(1);
        chk("nom_release", 32'(state_o), 32'd3);
        chk("nom_release_req", 32'(mem_ss_rst_req), 32'd0);
        step(2);
        chk("nom_release_hold", 32'(state_o), 32'd3);
        mem_ss_rst_ack_n = 1'b1;
        step(1);
        chk("nom_wait_cal", 32'(state_o), 32'd4);
        step(100);
        chk("nom_cal_pending", 32'(ready), 32'd0);
        pulse_start(4'hF);
        chk("nom_start_ignored", 32'(state_o), 32'd4);
        cal_success = 4'b0011;
        step(1);
        chk("nom_cal_status", 32'(cal_status), 32'h3);
        step(1);
        chk("nom_not_early", 32'(ready), 32'd0);
        step(1);
        chk("nom_ready", 32'(ready), 32'd1);
        chk("nom_done_state", 32'(state_o), 32'd5);
        chk("nom_done_busy", 32'(busy), 32'd0);
        chk("nom_retry", 32'(retry_cnt), 32'd0);
        chk("nom_err", 32'(err_code), 32'd0);
        cal_success = 4'b0001;
        step(2);
        chk("nom_cal_loss_status", 32'(cal_status), 32'h1);
        chk("nom_cal_loss_ready", 32'(ready), 32'd1);
        cal_success = 4'h0;

        // Ack timeout: ack_n never drops, three passes then ERROR
        pulse_start(4'b0011);
        chk("ato_restart_err", 32'(err_code), 32'd0);
        wait_state(3'd2, 20, "ato_wait_ack1");
        step(4095);
        chk("ato_edge", 32'(state_o), 32'd2);
        step(1);
        chk("ato_retry1_state", 32'(state_o), 32'd1);
        chk("ato_retry1", 32'(retry_cnt), 32'd1);
        chk("ato_err1", 32'(err_code), 32'd1);
        chk("ato_req_again", 32'(mem_ss_rst_req), 32'd1);
        wait_state(3'd2, 20, "ato_wait_ack2");
        step(4096);
        chk("ato_retry2", 32'(retry_cnt), 32'd2);
        wait_state(3'd2, 20, "ato_wait_ack3");
        step(4096);
        chk("ato_error_state", 32'(state_o), 32'd6);
        chk("ato_error", 32'(error), 32'd1);
        chk("ato_err_code", 32'(err_code), 32'd1);
        chk("ato_req_low", 32'(mem_ss_rst_req), 32'd0);
        chk("ato_busy_low", 32'(busy), 32'd0);
        step(3);
        chk("ato_error_held", 32'(error), 32'd1);

        // Cal fail on first pass (fail beats simultaneous success), clean second pass
        pulse_start(4'b0011);
        chk("cf_retry_clear", 32'(retry_cnt), 32'd0);
        chk("cf_err_clear", 32'(err_code), 32'd0);
        pass_ack();
        cal_fail = 4'b0001;
        cal_success = 4'b0011;
        step(1);
        chk("cf_retry_state", 32'(state_o), 32'd1);
        chk("cf_retry1", 32'(retry_cnt), 32'd1);
        chk("cf_err3", 32'(err_code), 32'd3);
        cal_fail = 4'h0;
        cal_success = 4'h0;
        pass_ack();
        cal_success = 4'b0011;
        step(3);
        chk("cf_ready", 32'(ready), 32'd1);
        chk("cf_retry_kept", 32'(retry_cnt), 32'd1);
        chk("cf_err_kept", 32'(err_code), 32'd3);
        cal_success = 4'h0;

        // Glitchy success: 2 high, 1 low, then steady
        pulse_start(4'b0011);
        pass_ack();
        cal_success = 4'b0011;
        step(2);
        cal_success = 4'b0001;
        step(1);
        chk("gl_no_ready_glitch", 32'(ready), 32'd0);
        cal_success = 4'b0011;
        step(2);
        chk("gl_no_early", 32'(ready), 32'd0);
        step(1);
        chk("gl_ready", 32'(ready), 32'd1);
        cal_success = 4'h0;

        // Mid-sequence reset in WAIT_CAL
        pulse_start(4'b0011);
        pass_ack();
        cal_success = 4'b0001;
        step(1);
        chk("mr_status_before", 32'(cal_status), 32'h1);
        rst = 1'b1;
        step(1);
        chk_idle_outputs("mr");
        rst = 1'b0;
        step(5);
        chk("mr_stay_idle", 32'(state_o), 32'd0);
        chk("mr_req_low", 32'(mem_ss_rst_req), 32'd0);
        chk("mr_mask_cleared", 32'(cal_status), 32'h0);
        cal_success = 4'h0;

        // Unmasked failing channel is ignored
        cal_fail = 4'b1000;
        pulse_start(4'b0111);
        pass_ack();
        cal_success = 4'b0111;
        step(3);
        chk("um_ready", 32'(ready), 32'd1);
        chk("um_err", 32'(err_code), 32'd0);
        chk("um_retry", 32'(retry_cnt), 32'd0);
        cal_success = 4'h0;
        cal_fail = 4'h0;

        // Zero mask completes without any success activity
        pulse_start(4'b0000);
        pass_ack();
        step(2);
        chk("zm_not_early", 32'(ready), 32'd0);
        step(1);
        chk("zm_ready", 32'(ready), 32'd1);
        chk("zm_status", 32'(cal_status), 32'h0);

        // Cal timeout boundary (CAL_TIMEOUT=512): success completing on the timeout cycle wins
        pulse_start(4'b0011);
        pass_ack();
        step(509);
        cal_success = 4'b0011;
        step(3);
        chk("ct_success_wins", 32'(state_o), 32'd5);
        chk("ct_success_err", 32'(err_code), 32'd0);
        cal_success = 4'h0;
        pulse_start(4'b0011);
        pass_ack();
        step(510);
        cal_success = 4'b0011;
        step(2);
        chk("ct_timeout_state", 32'(state_o), 32'd1);
        chk("ct_timeout_err", 32'(err_code), 32'd2);
        chk("ct_timeout_retry", 32'(retry_cnt), 32'd1);
        cal_success = 4'h0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
